stream_upsize: RTL and testbench

STREAM_UPSIZE -- requirements
Module: stream_upsize

---
 rtl/stream_upsize.sv | 126 ++++++++++++
 tb/tb_stream_upsize.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsize.sv
// Narrow-to-wide stream packer: gathers RATIO beats of IN_WIDTH bits into one wide word.
// Optional STREAM_UPSIZE_LAST_EN adds up_last/down_last/down_keep for short, early-terminated words.
module stream_upsize #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      up_valid,
  input  logic [IN_WIDTH-1:0]       up_data,
  output logic                      up_ready,
`ifdef STREAM_UPSIZE_LAST_EN
  input  logic                      up_last,
  output logic                      down_last,
  output logic [RATIO-1:0]          down_keep,
`endif
  output logic                      down_valid,
  output logic [IN_WIDTH*RATIO-1:0] down_data,
  input  logic                      down_ready
);

  localparam int OUT_W = IN_WIDTH * RATIO;
  localparam int CNT_W = $clog2(RATIO);

  logic [CNT_W-1:0]    r_cnt;
  logic [IN_WIDTH-1:0] r_buf [RATIO-1];
  logic [OUT_W-1:0]    r_data;
  logic                r_valid;
`ifdef STREAM_UPSIZE_LAST_EN
  logic [RATIO-1:0]    r_keep;
  logic                r_last;
`endif

  logic                w_lastLane;
  logic                w_complete;
  logic                w_stall;
  logic                w_accept;
  logic                w_xfer;
  logic [OUT_W-1:0]    w_word;
  logic [RATIO-1:0]    w_keep;

  assign w_lastLane = (r_cnt == CNT_W'(RATIO - 1));
`ifdef STREAM_UPSIZE_LAST_EN
  assign w_complete = w_lastLane | up_last;
`else
  assign w_complete = w_lastLane;
`endif

  // A completing beat may only enter when the output register is free or emptying now.
  assign w_stall  = w_complete & r_valid & ~down_ready;
  assign up_ready = ~rst_i & ~w_stall;
  assign w_accept = up_valid & up_ready;
  assign w_xfer   = r_valid & down_ready;

  // Lanes below cnt come from the buffer, lane cnt is the live beat, lanes above stay zero.
  always_comb begin
    w_word = '0;
    w_keep = '0;
    for (int j = 0; j < RATIO - 1; j++) begin
      if (CNT_W'(j) < r_cnt) begin
        w_word[j*IN_WIDTH +: IN_WIDTH] = r_buf[j];
        w_keep[j] = 1'b1;
      end else if (CNT_W'(j) == r_cnt) begin
        w_word[j*IN_WIDTH +: IN_WIDTH] = up_data;
        w_keep[j] = 1'b1;
      end
    end
    if (w_lastLane) begin
      w_word[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = up_data;
      w_keep[RATIO-1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      for (int j = 0; j < RATIO - 1; j++) begin
        r_buf[j] <= '0;
      end
    end else if (w_accept) begin
      if (w_complete) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        for (int j = 0; j < RATIO - 1; j++) begin
          if (r_cnt == CNT_W'(j)) begin
            r_buf[j] <= up_data;
          end
        end
      end
    end
  end

  // A new word may load in the same cycle the previous one leaves, keeping valid high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_data  <= '0;
      r_valid <= 1'b0;
`ifdef STREAM_UPSIZE_LAST_EN
      r_keep  <= '0;
      r_last  <= 1'b0;
`endif
    end else if (w_accept && w_complete) begin
      r_data  <= w_word;
      r_valid <= 1'b1;
`ifdef STREAM_UPSIZE_LAST_EN
      r_keep  <= w_keep;
      r_last  <= up_last;
`endif
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

`ifdef STREAM_UPSIZE_LAST_EN
  assign down_keep = r_keep;
  assign down_last = r_last;
`else
  logic w_keepUnused;
  assign w_keepUnused = &w_keep;
`endif

  assign down_valid = r_valid;
  assign down_data  = r_data;

endmodule

// File: tb/tb_stream_upsize.sv
// Self-checking bench for stream_upsize: queue-based packing model plus directed literal checks.
// Build with STREAM_UPSIZE_LAST_EN defined to also exercise the last/keep ports.
module tb_stream_upsize;

  localparam int IN_WIDTH = 8;
  localparam int RATIO    = 4;
  localparam int OUT_W    = IN_WIDTH * RATIO;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                up_valid = 1'b0;
  logic [IN_WIDTH-1:0] up_data = '0;
  logic                up_ready;
  logic                down_valid;
  logic [OUT_W-1:0]    down_data;
  logic                down_ready = 1'b0;
`ifdef STREAM_UPSIZE_LAST_EN
  logic                up_last = 1'b0;
  logic                down_last;
  logic [RATIO-1:0]    down_keep;
`endif

  int checks = 0;
  int errors = 0;

  stream_upsize #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
`ifdef STREAM_UPSIZE_LAST_EN
    .up_last    (up_last),
    .down_last  (down_last),
    .down_keep  (down_keep),
`endif
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive just after an edge, return just after the next edge.
  task automatic applyStimulus(input logic v, input logic [IN_WIDTH-1:0] d, input logic dr);
    up_valid   = v;
    up_data    = d;
    down_ready = dr;
`ifdef STREAM_UPSIZE_LAST_EN
    up_last    = 1'b0;
`endif
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: accepted beats queue up; every RATIO of them (or a last beat) forms a word.
  logic [IN_WIDTH-1:0] partQ [$];
  logic [OUT_W-1:0]    wordQ [$];
  logic [OUT_W-1:0]    xferLog [$];
  logic [OUT_W-1:0]    modelWord;
  int                  xferCnt = 0;
  int                  modelWords = 0;
  logic                beatLast;
`ifdef STREAM_UPSIZE_LAST_EN
  logic [RATIO-1:0]    keepQ [$];
  logic                lastQ [$];
`endif

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      partQ.delete();
      wordQ.delete();
`ifdef STREAM_UPSIZE_LAST_EN
      keepQ.delete();
      lastQ.delete();
`endif
    end else begin
      if (down_valid && down_ready) begin
        xferLog.push_back(down_data);
        xferCnt++;
        if (wordQ.size() > 0) begin
          void'(wordQ.pop_front());
`ifdef STREAM_UPSIZE_LAST_EN
          void'(keepQ.pop_front());
          void'(lastQ.pop_front());
`endif
        end
      end
      if (up_valid && up_ready) begin
        partQ.push_back(up_data);
`ifdef STREAM_UPSIZE_LAST_EN
        beatLast = up_last;
`else
        beatLast = 1'b0;
`endif
        if (partQ.size() == RATIO || beatLast) begin
          modelWord = '0;
          for (int i = 0; i < partQ.size(); i++) begin
            modelWord[i*IN_WIDTH +: IN_WIDTH] = partQ[i];
          end
          wordQ.push_back(modelWord);
`ifdef STREAM_UPSIZE_LAST_EN
          keepQ.push_back(RATIO'((1 << partQ.size()) - 1));
          lastQ.push_back(beatLast);
`endif
          modelWords++;
          partQ.delete();
        end
      end
    end
  end

  // Compare DUT against the model every cycle away from the active edge.
  logic expComplete;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      expComplete = (partQ.size() == RATIO - 1);
`ifdef STREAM_UPSIZE_LAST_EN
      expComplete = expComplete || (up_valid && up_last);
`endif
      checkOutput("model_down_valid", down_valid, wordQ.size() > 0);
      if (wordQ.size() > 0) begin
        checkOutput("model_down_data", down_data, wordQ[0]);
`ifdef STREAM_UPSIZE_LAST_EN
        checkOutput("model_down_keep", down_keep, keepQ[0]);
        checkOutput("model_down_last", down_last, lastQ[0]);
`endif
      end
      checkOutput("model_up_ready", up_ready,
                  !(expComplete && wordQ.size() > 0 && !down_ready));
    end
  end

  int logBase;

  initial begin
    // Reset values hold before any clock edge.
    #2;
    checkOutput("rst_up_ready", up_ready, 0);
    checkOutput("rst_down_valid", down_valid, 0);
    checkOutput("rst_down_data", down_data, 0);
`ifdef STREAM_UPSIZE_LAST_EN
    checkOutput("rst_down_keep", down_keep, 0);
    checkOutput("rst_down_last", down_last, 0);
`endif
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_up_ready", up_ready, 1);

    // Basic packing with one-cycle valid pulse.
    applyStimulus(1, 8'h11, 1);
    applyStimulus(1, 8'h22, 1);
    applyStimulus(1, 8'h33, 1);
    applyStimulus(1, 8'h44, 1);
    checkOutput("basic_valid", down_valid, 1);
    checkOutput("basic_data", down_data, 64'h44332211);
    applyStimulus(0, 8'h00, 1);
    checkOutput("basic_valid_drop", down_valid, 0);

    // Back-to-back streaming.
    xferLog.delete();
    for (int i = 0; i < 16; i++) begin
      up_valid = 1'b1;
      up_data = IN_WIDTH'(i);
      down_ready = 1'b1;
      #1;
      checkOutput("stream_up_ready", up_ready, 1);
      @(posedge clk_i);
      #1;
    end
    applyStimulus(0, 8'h00, 1);
    checkOutput("stream_word_count", xferLog.size(), 4);
    if (xferLog.size() == 4) begin
      checkOutput("stream_word0", xferLog[0], 64'h03020100);
      checkOutput("stream_word1", xferLog[1], 64'h07060504);
      checkOutput("stream_word2", xferLog[2], 64'h0B0A0908);
      checkOutput("stream_word3", xferLog[3], 64'h0F0E0D0C);
    end

    // Backpressure: one word held, three beats buffered, fourth stalls until release.
    for (int i = 0; i < 4; i++) applyStimulus(1, IN_WIDTH'(8'hA0 + i), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, IN_WIDTH'(8'hB0 + i), 0);
    up_valid = 1'b1;
    up_data = 8'hB3;
    down_ready = 1'b0;
    #1;
    checkOutput("bp_up_ready_low", up_ready, 0);
    checkOutput("bp_held_data", down_data, 64'hA3A2A1A0);
    @(posedge clk_i);
    #1;
    checkOutput("bp_still_held", down_data, 64'hA3A2A1A0);
    checkOutput("bp_still_valid", down_valid, 1);
    logBase = xferLog.size();
    down_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", up_ready, 1);
    @(posedge clk_i);
    #1;
    checkOutput("bp_new_word", down_data, 64'hB3B2B1B0);
    checkOutput("bp_valid_kept", down_valid, 1);
    checkOutput("bp_xfer_count", xferLog.size(), logBase + 1);
    if (xferLog.size() > 0) checkOutput("bp_xfer_word", xferLog[xferLog.size()-1], 64'hA3A2A1A0);
    applyStimulus(0, 8'h00, 1);

    // Mid-word asynchronous reset discards partial beats.
    applyStimulus(1, 8'hAA, 1);
    applyStimulus(1, 8'hBB, 1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_up_ready", up_ready, 0);
    checkOutput("midrst_down_data", down_data, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 1; i <= 4; i++) applyStimulus(1, IN_WIDTH'(i), 1);
    checkOutput("midrst_valid", down_valid, 1);
    checkOutput("midrst_data", down_data, 64'h04030201);
    applyStimulus(0, 8'h00, 1);

`ifdef STREAM_UPSIZE_LAST_EN
    // Early termination by up_last.
    applyStimulus(1, 8'h55, 1);
    up_valid = 1'b1;
    up_data = 8'h66;
    up_last = 1'b1;
    @(posedge clk_i);
    #1;
    up_valid = 1'b0;
    up_last = 1'b0;
    checkOutput("last_data", down_data, 64'h00006655);
    checkOutput("last_keep", down_keep, 4'b0011);
    checkOutput("last_last", down_last, 1);
    applyStimulus(0, 8'h00, 1);
`endif

    // Randomised valid/ready; the model does the checking each cycle.
    xferCnt = 0;
    modelWords = 0;
    for (int i = 0; i < 10000; i++) begin
      up_valid = ($urandom_range(0, 9) < 7);
      up_data = IN_WIDTH'($urandom);
      down_ready = ($urandom_range(0, 9) < 6);
`ifdef STREAM_UPSIZE_LAST_EN
      up_last = up_valid && ($urandom_range(0, 7) == 0);
`endif
      @(posedge clk_i);
      #1;
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 1);
    checkOutput("rand_word_total", xferCnt, modelWords);
    checkOutput("rand_drained", down_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
